// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: default widths, check-unit FSM states and
// the saturating subtract used for offset min-sum correction.
package ldpc_pkg;

  localparam int unsigned WIDTH_LLR      = 5;
  localparam int unsigned MAX_BLOCK_SIZE = 8;
  localparam int unsigned WIDTH_BLOCK    = $clog2(MAX_BLOCK_SIZE);

  // One-hot check-unit states
  typedef enum logic [4:0] {
    StIdle    = 5'b00001,
    StCollect = 5'b00010,
    StResolve = 5'b00100,
    StEmit    = 5'b01000,
    StDone    = 5'b10000
  } pcub_state_e;

  // a - b clamped at zero
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/pcub_min2_tracker.sv
// Running two-smallest magnitude tracker with index of the smallest and
// XOR parity of all accepted signs.
module pcub_min2_tracker #(
  parameter int unsigned WIDTH_LLR = 5,
  parameter int unsigned IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 update,
  input  logic [WIDTH_LLR-1:0] mag,
  input  logic                 sign,
  input  logic [IDX_W-1:0]     idx,
  output logic [WIDTH_LLR-1:0] min1,
  output logic [WIDTH_LLR-1:0] min2,
  output logic [IDX_W-1:0]     min1_idx,
  output logic                 parity
);

  // Strict compares keep the earliest index on ties and push the equal value into min2
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      min1     <= '1;
      min2     <= '1;
      min1_idx <= '0;
      parity   <= 1'b0;
    end else if (update) begin
      parity <= parity ^ sign;
      if (mag < min1) begin
        min2     <= min1;
        min1     <= mag;
        min1_idx <= idx;
      end else if (mag < min2) begin
        min2 <= mag;
      end
    end
  end

endmodule

// File: rtl/pcub_minsum.sv
// Offset min-sum check-node unit: collects one check row of bit-to-check
// messages, then streams back check-to-bit messages in arrival order.
module pcub_minsum #(
  parameter int unsigned  WIDTH_LLR      = ldpc_pkg::WIDTH_LLR,
  parameter int unsigned  MAX_DEG        = 8,
  parameter int unsigned  MAX_BLOCK_SIZE = ldpc_pkg::MAX_BLOCK_SIZE,
  parameter int unsigned  OFFSET         = 0,
  localparam int unsigned WIDTH_BLOCK    = $clog2(MAX_BLOCK_SIZE),
  localparam int unsigned CNT_W          = $clog2(MAX_DEG + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       row_weight,
  input  logic                   in_valid,
  input  logic [WIDTH_LLR-1:0]   in_mag,
  input  logic                   in_sign,
  input  logic [WIDTH_BLOCK-1:0] in_col,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH_LLR-1:0]   out_mag,
  output logic                   out_sign,
  output logic [WIDTH_BLOCK-1:0] out_col,
  output logic                   done,
  output logic                   busy
);

  import ldpc_pkg::*;

  localparam int unsigned IDX_W = (MAX_DEG > 1) ? $clog2(MAX_DEG) : 1;

  pcub_state_e state_q;

  logic [CNT_W-1:0]       weight_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       ptr_q;
  logic [CNT_W-1:0]       weight_in;
  logic [WIDTH_LLR-1:0]   mag_buf  [MAX_DEG];
  logic                   sign_buf [MAX_DEG];
  logic [WIDTH_BLOCK-1:0] col_buf  [MAX_DEG];

  logic                   accept;
  logic                   last_beat;
  logic                   start_row;
  logic [WIDTH_LLR-1:0]   min1;
  logic [WIDTH_LLR-1:0]   min2;
  logic [IDX_W-1:0]       min1_idx;
  logic                   parity;
  logic [WIDTH_LLR-1:0]   m1;
  logic [WIDTH_LLR-1:0]   m2;

  logic [CNT_W-1:0]       ld_ptr;
  logic [IDX_W-1:0]       ld_idx;
  logic [WIDTH_LLR-1:0]   ld_mag;
  logic                   ld_sign;
  logic [WIDTH_BLOCK-1:0] ld_col;

  // in_ready is registered and only high in COLLECT, so it gates all stores
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && ((cnt_q + CNT_W'(1)) == weight_q);
  assign start_row = start && (state_q == StIdle);

  assign m1 = WIDTH_LLR'(sat_sub(32'(min1), OFFSET));
  assign m2 = WIDTH_LLR'(sat_sub(32'(min2), OFFSET));

  // Clamp out-of-range row weights into 1..MAX_DEG
  always_comb begin
    weight_in = row_weight;
    if (row_weight == '0) begin
      weight_in = CNT_W'(1);
    end else if (row_weight > CNT_W'(MAX_DEG)) begin
      weight_in = CNT_W'(MAX_DEG);
    end
  end

  pcub_min2_tracker #(
    .WIDTH_LLR (WIDTH_LLR),
    .IDX_W     (IDX_W)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_row),
    .update   (accept),
    .mag      (in_mag),
    .sign     (in_sign),
    .idx      (cnt_q[IDX_W-1:0]),
    .min1     (min1),
    .min2     (min2),
    .min1_idx (min1_idx),
    .parity   (parity)
  );

  // Entry store; contents are don't-care outside a row so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mag_buf[cnt_q[IDX_W-1:0]]  <= in_mag;
      sign_buf[cnt_q[IDX_W-1:0]] <= in_sign;
      col_buf[cnt_q[IDX_W-1:0]]  <= in_col;
    end
  end

  // Next output entry: entry 0 when leaving RESOLVE, otherwise ptr+1
  always_comb begin
    ld_ptr  = (state_q == StResolve) ? '0 : (ptr_q + CNT_W'(1));
    ld_idx  = ld_ptr[IDX_W-1:0];
    ld_col  = col_buf[ld_idx];
    ld_sign = parity ^ sign_buf[ld_idx];
    if (weight_q == CNT_W'(1)) begin
      // A lone entry has no extrinsic information
      ld_mag  = '0;
      ld_sign = 1'b0;
    end else if (ld_idx == min1_idx) begin
      ld_mag = m2;
    end else begin
      ld_mag = m1;
    end
  end

  // Control FSM with registered handshake and data outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      weight_q  <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_sign  <= 1'b0;
      out_col   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StCollect;
            weight_q <= weight_in;
            cnt_q    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StCollect: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat) begin
              in_ready <= 1'b0;
              state_q  <= StResolve;
            end
          end
        end
        StResolve: begin
          ptr_q     <= '0;
          out_valid <= 1'b1;
          out_mag   <= ld_mag;
          out_sign  <= ld_sign;
          out_col   <= ld_col;
          state_q   <= StEmit;
        end
        StEmit: begin
          if (out_ready) begin
            if (ptr_q == (weight_q - CNT_W'(1))) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state_q   <= StDone;
            end else begin
              ptr_q    <= ld_ptr;
              out_mag  <= ld_mag;
              out_sign <= ld_sign;
              out_col  <= ld_col;
            end
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
